skew_feeder: RTL and testbench



---
 rtl/skew_feeder.sv | 91 +++++++++
 tb/tb_skew_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : skew_feeder
// Brief    : Re-times transposed byte vectors into a diagonal wavefront for a
//            systolic PE row; tracks tile progress and busy status.
// Revision : 1.0
// ============================================================================
module skew_feeder #(
    parameter int WORD_SIZE = 128,
    parameter int LANES     = 8,
    parameter int BYTE_W    = 8,
    parameter int TILE_ROWS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WORD_SIZE-1:0]    in_data,
    output logic [LANES*BYTE_W-1:0] out_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    tile_done,
    output logic [4:0]              vec_cnt,
    output logic                    busy
);

    localparam logic [4:0] c_LAST_ROW = 5'(TILE_ROWS - 1);

    logic [4:0]       r_vec_cnt;
    logic [LANES-1:0] r_done;
    logic [LANES-1:0] w_lane_busy;
    logic             w_last;

    assign w_last = in_valid && (r_vec_cnt == c_LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_cnt <= '0;
            r_done    <= '0;
        end else begin
            if (in_valid) begin
                r_vec_cnt <= w_last ? 5'd0 : r_vec_cnt + 5'd1;
            end
            r_done <= {r_done[LANES-2:0], w_last};
        end
    end

    // Lane k is a (k+1)-stage shift register; its last stage drives the output.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BYTE_W-1:0]         w_byte;
        logic [k:0]                r_vld;
        logic [(k+1)*BYTE_W-1:0]   r_data;

        assign w_byte = in_valid ? in_data[WORD_SIZE-1-k*BYTE_W -: BYTE_W] : '0;

        if (k == 0) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= '0;
                    r_data <= '0;
                end else begin
                    r_vld  <= in_valid;
                    r_data <= w_byte;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= '0;
                    r_data <= '0;
                end else begin
                    r_vld  <= {r_vld[k-1:0], in_valid};
                    r_data <= {r_data[k*BYTE_W-1:0], w_byte};
                end
            end
        end

        assign out_data[k*BYTE_W +: BYTE_W] = r_data[(k+1)*BYTE_W-1 -: BYTE_W];
        assign out_lane_valid[k]            = r_vld[k];
        assign w_lane_busy[k]               = |r_vld;
    end

    if (WORD_SIZE > LANES*BYTE_W) begin : g_unused_lsbs
        logic w_unused;
        assign w_unused = ^in_data[WORD_SIZE-LANES*BYTE_W-1:0];
    end

    assign tile_done = r_done[LANES-1];
    assign vec_cnt   = r_vec_cnt;
    assign busy      = (r_vec_cnt != 5'd0) || (|w_lane_busy) || (|r_done);

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_feeder
// Brief    : Directed, table-driven bench for skew_feeder.
// Revision : 1.0
// ============================================================================
module tb_skew_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic [63:0]  out_data;
    logic [7:0]   out_lane_valid;
    logic         tile_done;
    logic [4:0]   vec_cnt;
    logic         busy;

    skew_feeder #(.WORD_SIZE(128), .LANES(8), .BYTE_W(8), .TILE_ROWS(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .tile_done      (tile_done),
        .vec_cnt        (vec_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] din;
        logic [63:0] e_data;
        logic [7:0]  e_lv;
        logic [4:0]  e_cnt;
        logic        e_busy;
    } row_t;

    row_t        tbl [10];
    logic        hv    [512];
    logic [63:0] hd    [512];
    logic        hdone [512];
    int          cyc, base, m_cnt;
    int          n_chk, n_fail;
    int          done_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs for the current cycle, derived from the accepted-input history.
    task automatic check_model();
        logic [63:0] ed;
        logic [7:0]  ev;
        logic        eb;
        logic        edn;
        int          j;
        ed  = '0;
        ev  = '0;
        eb  = (m_cnt != 0);
        edn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = cyc - 1 - k;
            if (j >= base && hv[j]) begin
                ev[k]        = 1'b1;
                ed[8*k +: 8] = hd[j][63-8*k -: 8];
            end
        end
        for (int i = 1; i <= 8; i++) begin
            j = cyc - i;
            if (j >= base && hv[j]) eb = 1'b1;
        end
        j = cyc - 8;
        if (j >= base && hdone[j]) edn = 1'b1;
        if (tile_done === 1'b1) done_log.push_back(cyc);
        chk("out_data",       out_data,       ed);
        chk("out_lane_valid", 64'(out_lane_valid), 64'(ev));
        chk("tile_done",      64'(tile_done), 64'(edn));
        chk("vec_cnt",        64'(vec_cnt),   64'(m_cnt));
        chk("busy",           64'(busy),      64'(eb));
    endtask

    task automatic tick(input logic v, input logic [63:0] d);
        in_valid   = v;
        in_data    = {d, $urandom, $urandom};
        hv[cyc]    = v;
        hd[cyc]    = v ? d : 64'd0;
        hdone[cyc] = 1'b0;
        if (v) begin
            if (m_cnt == 15) begin
                hdone[cyc] = 1'b1;
                m_cnt      = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic idle();
        tick(1'b0, {$urandom, $urandom});
    endtask

    // Assert reset between edges, confirm outputs clear without a clock, release after one edge.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_data",  out_data,            64'd0);
        chk("rst_lane_vld",  64'(out_lane_valid), 64'd0);
        chk("rst_tile_done", 64'(tile_done),      64'd0);
        chk("rst_vec_cnt",   64'(vec_cnt),        64'd0);
        chk("rst_busy",      64'(busy),           64'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst   = 1'b0;
        base  = cyc;
        m_cnt = 0;
    endtask

    function automatic logic [63:0] pat(input int r, input logic inv);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d[63-8*k -: 8] = 8'(r*16 + k) ^ (inv ? 8'hFF : 8'h00);
        end
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, acc, p, last;
        logic v;
        n_chk = 0; n_fail = 0; cyc = 0; base = 0; m_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            hv[i] = 1'b0; hd[i] = '0; hdone[i] = 1'b0;
        end
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        do_reset();
        for (int i = 0; i < 20; i++) idle();

        // Single vector: lane k shows k+1 alone at cycle k+1.
        for (int i = 0; i < 10; i++) begin
            tbl[i].vld    = (i == 0);
            tbl[i].din    = (i == 0) ? 64'h0102_0304_0506_0708 : 64'hFFFF_FFFF_FFFF_FFFF;
            tbl[i].e_data = (i < 8) ? (64'(i + 1) << (8*i)) : 64'd0;
            tbl[i].e_lv   = (i < 8) ? 8'(1 << i) : 8'd0;
            tbl[i].e_cnt  = 5'd1;
            tbl[i].e_busy = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].vld, tbl[i].din);
            chk("tbl_data",  out_data,            tbl[i].e_data);
            chk("tbl_lv",    64'(out_lane_valid), 64'(tbl[i].e_lv));
            chk("tbl_cnt",   64'(vec_cnt),        64'(tbl[i].e_cnt));
            chk("tbl_busy",  64'(busy),           64'(tbl[i].e_busy));
            chk("tbl_done",  64'(tile_done),      64'd0);
        end

        // Full tile of 16 back-to-back vectors.
        do_reset();
        t0 = cyc;
        done_log.delete();
        for (int r = 0; r < 16; r++) tick(1'b1, pat(r, 1'b0));
        chk("tile_cnt_wrap", 64'(vec_cnt), 64'd0);
        while (cyc < t0 + 23) idle();
        chk("tile_done_23",  64'(tile_done),       64'd1);
        chk("tile_busy_23",  64'(busy),            64'd1);
        chk("tile_lane7_23", 64'(out_data[63:56]), 64'hF7);
        idle();
        chk("tile_busy_24",  64'(busy),            64'd0);
        chk("tile_done_n",   64'(done_log.size()), 64'd1);
        chk("tile_done_at",  64'(done_log.size() > 0 ? done_log[0] - t0 : -1), 64'd23);

        // Two tiles back-to-back; second tile uses inverted bytes.
        t0 = cyc;
        done_log.delete();
        for (int r = 0; r < 32; r++) tick(1'b1, pat(r % 16, r >= 16));
        while (cyc < t0 + 41) idle();
        chk("two_done_n",  64'(done_log.size()), 64'd2);
        chk("two_done_0",  64'(done_log.size() > 0 ? done_log[0] - t0 : -1), 64'd23);
        chk("two_done_1",  64'(done_log.size() > 1 ? done_log[1] - t0 : -1), 64'd39);

        // Bubbles: in_valid follows 1,0,1 repeating until 16 vectors accepted.
        done_log.delete();
        acc = 0; p = 0; last = 0;
        while (acc < 16) begin
            v = ((p % 3) != 1);
            tick(v, pat(acc, 1'b0) ^ 64'h5A5A_5A5A_5A5A_5A5A);
            if (v) begin
                last = cyc - 1;
                acc++;
            end
            p++;
        end
        for (int i = 0; i < 12; i++) idle();
        chk("bub_done_n",  64'(done_log.size()), 64'd1);
        chk("bub_done_at", 64'(done_log.size() > 0 ? done_log[0] - last : -1), 64'd8);

        // Reset at cycle 10 of a tile, then a fresh tile.
        done_log.delete();
        for (int r = 0; r < 10; r++) tick(1'b1, {$urandom, $urandom});
        do_reset();
        for (int i = 0; i < 20; i++) idle();
        chk("rst_no_done", 64'(done_log.size()), 64'd0);
        t0 = cyc;
        tick(1'b1, {$urandom, $urandom});
        chk("fresh_cnt1", 64'(vec_cnt), 64'd1);
        for (int r = 1; r < 16; r++) tick(1'b1, {$urandom, $urandom});
        while (cyc < t0 + 25) idle();
        chk("fresh_done_n",  64'(done_log.size()), 64'd1);
        chk("fresh_done_at", 64'(done_log.size() > 0 ? done_log[0] - t0 : -1), 64'd23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
